// File: rtl/add_and_square_power_acc.sv
// Beam power block: per-sample channel sum, centring and exact squaring,
// an adder tree across the demuxed samples, a windowed power accumulator and a threshold trigger.
module add_and_square_power_acc #(
    parameter  int DEMUX    = 16,
    parameter  int NBITS    = 3,
    parameter  int NCHAN    = 3,
    parameter  int ACC_LEN  = 8,
    localparam int DMAX     = NCHAN * ((1 << NBITS) - 1),
    localparam int SBITS    = $clog2(DMAX + 1),
    localparam int SQBITS   = 2 * SBITS,
    localparam int TREEBITS = SQBITS + $clog2(DEMUX),
    localparam int ACCBITS  = TREEBITS + $clog2(ACC_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [NCHAN*DEMUX*NBITS-1:0]   samples,
    input  logic [ACCBITS-1:0]             threshold,
    output logic [DEMUX*SQBITS-1:0]        sq_out,
    output logic                           sq_valid,
    output logic [ACCBITS-1:0]             power_out,
    output logic                           power_valid,
    output logic                           trig
);

    localparam int              CNTBITS = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [SBITS:0]  DMAX_W  = (SBITS + 1)'(DMAX);
    localparam logic [CNTBITS-1:0] LAST_CNT = CNTBITS'(ACC_LEN - 1);

    logic [SBITS-1:0]    s_next  [DEMUX];
    logic [SBITS-1:0]    s_q     [DEMUX];
    logic [SQBITS-1:0]   sq_next [DEMUX];
    logic [SQBITS-1:0]   sq_q    [DEMUX];
    logic [SBITS:0]      two_s;
    logic [SBITS:0]      mag;
    logic [TREEBITS-1:0] tree_next;
    logic [TREEBITS-1:0] tree_q;
    logic                v1, v2, v3;
    logic [ACCBITS-1:0]  acc;
    logic [ACCBITS-1:0]  acc_sum;
    logic [CNTBITS-1:0]  cnt;

    always_comb begin
        for (int i = 0; i < DEMUX; i++) begin
            s_next[i] = '0;
            for (int c = 0; c < NCHAN; c++) begin
                s_next[i] = s_next[i] + SBITS'(samples[((c * DEMUX) + i) * NBITS +: NBITS]);
            end
        end
    end

    // |2s - DMAX| is at most DMAX, so squaring the magnitude in SQBITS is exact.
    always_comb begin
        two_s = '0;
        mag   = '0;
        for (int i = 0; i < DEMUX; i++) begin
            two_s      = {s_q[i], 1'b0};
            mag        = (two_s >= DMAX_W) ? (two_s - DMAX_W) : (DMAX_W - two_s);
            sq_next[i] = SQBITS'(mag) * SQBITS'(mag);
        end
    end

    always_comb begin
        tree_next = '0;
        for (int i = 0; i < DEMUX; i++) begin
            tree_next = tree_next + TREEBITS'(sq_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEMUX; i++) begin
            sq_out[i*SQBITS +: SQBITS] = sq_q[i];
        end
    end

    assign sq_valid = v2;
    assign acc_sum  = acc + ACCBITS'(tree_q);

    // Data registers load only behind a valid bit, so bubbles and clear leave them holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            tree_q <= '0;
            // NOTE: the per-sample arrays are plain registers, not RAM, so they are reset like any other flop.
            for (int i = 0; i < DEMUX; i++) begin
                s_q[i]  <= '0;
                sq_q[i] <= '0;
            end
        end else if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            for (int i = 0; i < DEMUX; i++) begin
                if (in_valid) s_q[i]  <= s_next[i];
                if (v1)       sq_q[i] <= sq_next[i];
            end
            if (v2) tree_q <= tree_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            power_out   <= '0;
            power_valid <= 1'b0;
            trig        <= 1'b0;
        end else begin
            power_valid <= 1'b0;
            trig        <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (v3) begin
                if (cnt == LAST_CNT) begin
                    power_out   <= acc_sum;
                    power_valid <= 1'b1;
                    trig        <= (acc_sum > threshold);
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_and_square_power_acc.sv
// Bench for add_and_square_power_acc: transaction-level reference model compared every cycle,
// plus hand-computed expectations from the directed cases.
module tb_add_and_square_power_acc;

    localparam int DEMUX   = 16;
    localparam int NBITS   = 3;
    localparam int NCHAN   = 3;
    localparam int ACC_LEN = 8;
    localparam int DMAX    = 21;
    localparam int SQBITS  = 10;
    localparam int ACCBITS = 18;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         clear;
    logic                         in_valid;
    logic [NCHAN*DEMUX*NBITS-1:0] samples;
    logic [ACCBITS-1:0]           threshold;
    logic [DEMUX*SQBITS-1:0]      sq_out;
    logic                         sq_valid;
    logic [ACCBITS-1:0]           power_out;
    logic                         power_valid;
    logic                         trig;

    add_and_square_power_acc #(
        .DEMUX(DEMUX), .NBITS(NBITS), .NCHAN(NCHAN), .ACC_LEN(ACC_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .samples(samples), .threshold(threshold), .sq_out(sq_out),
        .sq_valid(sq_valid), .power_out(power_out), .power_valid(power_valid), .trig(trig)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: transactions in flight, window sum and count.
    bit      m_v1, m_v2, m_v3;
    longint  m_sq1 [DEMUX];
    longint  m_sq2 [DEMUX];
    longint  m_tree3;
    longint  m_acc, m_power;
    int      m_cnt;
    bit      m_pv, m_trig;

    int      cyc = 0;
    int      pulses, trigs, last_pulse, prev_pulse;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint square_of(input int i);
        int s = 0;
        int d;
        for (int c = 0; c < NCHAN; c++) s += int'(samples[((c * DEMUX) + i) * NBITS +: NBITS]);
        d = 2 * s - DMAX;
        return longint'(d * d);
    endfunction

    task automatic model_edge();
        longint t = 0;
        if (!rst_n) begin
            m_v1 = 0; m_v2 = 0; m_v3 = 0;
            m_acc = 0; m_cnt = 0; m_power = 0; m_pv = 0; m_trig = 0;
        end else if (clear) begin
            m_v1 = 0; m_v2 = 0; m_v3 = 0;
            m_acc = 0; m_cnt = 0; m_pv = 0; m_trig = 0;
        end else begin
            m_pv = 0; m_trig = 0;
            if (m_v3) begin
                if (m_cnt == ACC_LEN - 1) begin
                    m_power = m_acc + m_tree3;
                    m_pv    = 1;
                    m_trig  = (m_power > longint'(threshold));
                    m_acc   = 0;
                    m_cnt   = 0;
                end else begin
                    m_acc += m_tree3;
                    m_cnt++;
                end
            end
            for (int i = 0; i < DEMUX; i++) t += m_sq2[i];
            m_v3    = m_v2;
            if (m_v2) m_tree3 = t;
            m_v2    = m_v1;
            if (m_v1) m_sq2 = m_sq1;
            m_v1    = in_valid;
            for (int i = 0; i < DEMUX; i++) m_sq1[i] = square_of(i);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("sq_valid", sq_valid, m_v2);
        check("power_valid", power_valid, m_pv);
        check("trig", trig, m_trig);
        check("power_out", power_out, m_power);
        if (m_v2)
            for (int i = 0; i < DEMUX; i++)
                check("sq_out", sq_out[i*SQBITS +: SQBITS], m_sq2[i]);
        if (power_valid) begin
            pulses++;
            if (trig) trigs++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    endtask

    task automatic fill_const(input int c0, input int c1, input int c2);
        int code [NCHAN];
        code[0] = c0; code[1] = c1; code[2] = c2;
        for (int c = 0; c < NCHAN; c++)
            for (int i = 0; i < DEMUX; i++)
                samples[((c * DEMUX) + i) * NBITS +: NBITS] = NBITS'(code[c]);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NCHAN * DEMUX; k++)
            samples[k*NBITS +: NBITS] = NBITS'($urandom_range(0, 7));
    endtask

    task automatic run(input int n, input bit v);
        in_valid = v;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr_counts();
        pulses = 0; trigs = 0; last_pulse = 0; prev_pulse = 0;
    endtask

    int accept_cyc;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; threshold = '0;
        samples = '0;
        m_tree3 = 0;
        for (int i = 0; i < DEMUX; i++) begin m_sq1[i] = 0; m_sq2[i] = 0; end
        clr_counts();
        run(2, 0);
        check("reset power_out", power_out, 0);
        check("reset sq_out", sq_out[SQBITS-1:0], 0);
        rst_n = 1'b1;

        // All codes 7: first window, latency and value.
        fill_const(7, 7, 7);
        threshold = 18'd56447;
        clr_counts();
        run(8, 1);
        accept_cyc = cyc;
        check("sq_out all7", sq_out[SQBITS-1:0], 441);
        run(4, 0);
        check("all7 pulses", pulses, 1);
        check("all7 latency", last_pulse - accept_cyc, 3);
        check("all7 power", power_out, 56448);
        check("all7 trig count", trigs, 1);
        clr_counts();
        run(24, 1);
        run(4, 0);
        check("all7 repeat pulses", pulses, 3);
        check("all7 spacing", last_pulse - prev_pulse, 8);
        check("all7 repeat trigs", trigs, 3);

        // All codes 0 with threshold equal to the power: no trigger.
        fill_const(0, 0, 0);
        threshold = 18'd56448;
        clr_counts();
        run(16, 1);
        check("sq_out all0", sq_out[SQBITS-1:0], 441);
        run(4, 0);
        check("all0 pulses", pulses, 2);
        check("all0 trigs", trigs, 0);
        check("all0 power", power_out, 56448);

        // Codes 3,4,3 -> d = -1, window power 128, threshold either side.
        fill_const(3, 4, 3);
        threshold = 18'd127;
        clr_counts();
        run(8, 1);
        check("sq_out 343", sq_out[SQBITS-1:0], 1);
        run(4, 0);
        check("343 power", power_out, 128);
        check("343 trig thr127", trigs, 1);
        threshold = 18'd128;
        clr_counts();
        run(8, 1);
        run(4, 0);
        check("343 pulses thr128", pulses, 1);
        check("343 trig thr128", trigs, 0);

        // Alternating valid with saturating input: bubbles are not counted.
        fill_const(7, 7, 7);
        clr_counts();
        for (int k = 0; k < 32; k++) begin
            in_valid = (k % 2 == 0);
            tick();
        end
        run(4, 0);
        check("alt pulses", pulses, 2);
        check("alt spacing", last_pulse - prev_pulse, 16);
        check("alt power", power_out, 56448);

        // Clear after 5 valid cycles; the clear-cycle sample is discarded.
        clr_counts();
        run(5, 1);
        clear = 1'b1;
        run(1, 1);
        clear = 1'b0;
        run(7, 1);
        run(4, 0);
        check("clear early pulses", pulses, 0);
        run(1, 1);
        run(4, 0);
        check("clear pulses", pulses, 1);
        check("clear power", power_out, 56448);

        // Clear on the completion edge suppresses the pulse; power_out holds.
        fill_const(3, 4, 3);
        clr_counts();
        run(8, 1);
        run(2, 0);
        clear = 1'b1;
        run(1, 0);
        clear = 1'b0;
        run(3, 0);
        check("clear coincident pulses", pulses, 0);
        check("clear coincident hold", power_out, 56448);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            fill_random();
            in_valid  = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            threshold = ACCBITS'($urandom_range(0, 60000));
            tick();
        end
        clear = 1'b0;

        // Asynchronous reset mid-window.
        fill_const(7, 7, 7);
        run(8, 1);
        run(3, 0);
        run(5, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async power_out", power_out, 0);
        check("async power_valid", power_valid, 0);
        check("async sq_valid", sq_valid, 0);
        check("async sq_out", sq_out[SQBITS-1:0], 0);
        run(1, 0);
        rst_n = 1'b1;
        clr_counts();
        run(8, 1);
        run(4, 0);
        check("post reset pulses", pulses, 1);
        check("post reset power", power_out, 56448);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
